// File: rtl/main.sv
// rtl/main.sv - two-digit decimal adder with raw/ASCII digit inputs and registered BCD/ASCII outputs
//
// Ports:
//   clk                      rising-edge clock for all state
//   rst                      synchronous active-high reset
//   AD, AU                   tens / units digit of operand A (raw 0-9 or ASCII '0'-'9')
//   BD, BU                   tens / units digit of operand B (same encoding)
//   YC, YD, YU               hundreds / tens / units BCD digit of A + B
//   YC_ASC, YD_ASC, YU_ASC   ASCII codes of YC / YD / YU
//   ERR                      at least one input digit was invalid on the last edge

module main (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] AD,
    input  logic [6:0] AU,
    input  logic [6:0] BD,
    input  logic [6:0] BU,
    output logic [3:0] YC,
    output logic [3:0] YD,
    output logic [3:0] YU,
    output logic [6:0] YC_ASC,
    output logic [6:0] YD_ASC,
    output logic [6:0] YU_ASC,
    output logic       ERR
);

    // Returns {valid, digit}. Raw 0x00-0x09 and ASCII 0x30-0x39 both carry
    // the digit in the low nibble, so only the validity test differs.
    function automatic logic [4:0] f_decode(input logic [6:0] v);
        logic [4:0] res;
        res = 5'd0;
        if (v <= 7'd9) begin
            res = {1'b1, v[3:0]};
        end else if ((v[6:4] == 3'b011) && (v[3:0] <= 4'd9)) begin
            res = {1'b1, v[3:0]};
        end
        return res;
    endfunction

    logic [4:0] w_ad;
    logic [4:0] w_au;
    logic [4:0] w_bd;
    logic [4:0] w_bu;
    logic       w_valid;

    assign w_ad    = f_decode(AD);
    assign w_au    = f_decode(AU);
    assign w_bd    = f_decode(BD);
    assign w_bu    = f_decode(BU);
    assign w_valid = w_ad[4] & w_au[4] & w_bd[4] & w_bu[4];

    // Per-digit BCD addition. A digit sum above 9 produces a carry, and
    // adding 6 modulo 16 folds 10..19 back onto 0..9.
    logic [4:0] w_u_sum;
    logic       w_u_carry;
    logic [3:0] w_u_dig;
    logic [4:0] w_t_sum;
    logic       w_t_carry;
    logic [3:0] w_t_dig;

    assign w_u_sum   = {1'b0, w_au[3:0]} + {1'b0, w_bu[3:0]};
    assign w_u_carry = (w_u_sum > 5'd9);
    assign w_u_dig   = w_u_carry ? (w_u_sum[3:0] + 4'd6) : w_u_sum[3:0];

    assign w_t_sum   = {1'b0, w_ad[3:0]} + {1'b0, w_bd[3:0]} + {4'd0, w_u_carry};
    assign w_t_carry = (w_t_sum > 5'd9);
    assign w_t_dig   = w_t_carry ? (w_t_sum[3:0] + 4'd6) : w_t_sum[3:0];

    logic [3:0] r_yc;
    logic [3:0] r_yd;
    logic [3:0] r_yu;
    logic [6:0] r_yc_asc;
    logic [6:0] r_yd_asc;
    logic [6:0] r_yu_asc;
    logic       r_err;

    always_ff @(posedge clk) begin
        if (rst || !w_valid) begin
            // Reset and invalid input both force a zero result; only the
            // invalid case raises ERR.
            r_yc     <= 4'd0;
            r_yd     <= 4'd0;
            r_yu     <= 4'd0;
            r_yc_asc <= 7'h30;
            r_yd_asc <= 7'h30;
            r_yu_asc <= 7'h30;
            r_err    <= !rst;
        end else begin
            r_yc     <= {3'b000, w_t_carry};
            r_yd     <= w_t_dig;
            r_yu     <= w_u_dig;
            r_yc_asc <= 7'h30 + {6'd0, w_t_carry};
            r_yd_asc <= 7'h30 + {3'd0, w_t_dig};
            r_yu_asc <= 7'h30 + {3'd0, w_u_dig};
            r_err    <= 1'b0;
        end
    end

    assign YC     = r_yc;
    assign YD     = r_yd;
    assign YU     = r_yu;
    assign YC_ASC = r_yc_asc;
    assign YD_ASC = r_yd_asc;
    assign YU_ASC = r_yu_asc;
    assign ERR    = r_err;

endmodule

// File: tb/tb_main.sv
// tb/tb_main.sv - scoreboard testbench for the decimal adder

module tb_main;

    logic       clk;
    logic       rst;
    logic [6:0] AD;
    logic [6:0] AU;
    logic [6:0] BD;
    logic [6:0] BU;
    logic [3:0] YC;
    logic [3:0] YD;
    logic [3:0] YU;
    logic [6:0] YC_ASC;
    logic [6:0] YD_ASC;
    logic [6:0] YU_ASC;
    logic       ERR;

    int n_cmp = 0;
    int n_err = 0;

    // Packed result: {YC, YD, YU, YC_ASC, YD_ASC, YU_ASC, ERR}
    logic [33:0] sb[$];
    logic [33:0] exp_v;
    logic [33:0] got_v;

    main dut (
        .clk    (clk),
        .rst    (rst),
        .AD     (AD),
        .AU     (AU),
        .BD     (BD),
        .BU     (BU),
        .YC     (YC),
        .YD     (YD),
        .YU     (YU),
        .YC_ASC (YC_ASC),
        .YD_ASC (YD_ASC),
        .YU_ASC (YU_ASC),
        .ERR    (ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dec_digit(input logic [6:0] v);
        int x;
        x = int'(v);
        if (x >= 0 && x <= 9) return x;
        if (x >= 48 && x <= 57) return x - 48;
        return -1;
    endfunction

    function automatic logic [33:0] model(input logic r, input logic [6:0] ad,
                                          input logic [6:0] au, input logic [6:0] bd,
                                          input logic [6:0] bu);
        int da, ua, db, ub, s, c, d, u;
        logic [33:0] res;
        da = dec_digit(ad);
        ua = dec_digit(au);
        db = dec_digit(bd);
        ub = dec_digit(bu);
        if (r) begin
            res = {4'd0, 4'd0, 4'd0, 7'h30, 7'h30, 7'h30, 1'b0};
        end else if (da < 0 || ua < 0 || db < 0 || ub < 0) begin
            res = {4'd0, 4'd0, 4'd0, 7'h30, 7'h30, 7'h30, 1'b1};
        end else begin
            s = (10 * da + ua) + (10 * db + ub);
            c = s / 100;
            d = (s % 100) / 10;
            u = s % 10;
            res = {4'(c), 4'(d), 4'(u), 7'(48 + c), 7'(48 + d), 7'(48 + u), 1'b0};
        end
        return res;
    endfunction

    function automatic logic [33:0] observed();
        return {YC, YD, YU, YC_ASC, YD_ASC, YU_ASC, ERR};
    endfunction

    // Drives one input set, records the expected result, and advances one edge.
    task automatic apply(input logic r, input logic [6:0] ad, input logic [6:0] au,
                         input logic [6:0] bd, input logic [6:0] bu);
        rst = r;
        AD  = ad;
        AU  = au;
        BD  = bd;
        BU  = bu;
        sb.push_back(model(r, ad, au, bd, bu));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] rand_digit();
        logic [6:0] v;
        v = 7'($urandom_range(0, 9));
        if ($urandom_range(0, 1) == 1) v = v + 7'h30;
        return v;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 7'd9, 7'd9, 7'd9, 7'd9);
            exp_v = sb.pop_front();
            got_v = observed();
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL reset[%0d]: got %h expected %h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_raw();
        apply(1'b0, 7'd4, 7'd7, 7'd3, 7'd8);
        exp_v = sb.pop_front();
        got_v = observed();
        n_cmp++;
        if (got_v !== exp_v || {YC, YD, YU} !== 12'h085) begin
            n_err++;
            $display("FAIL raw_47_38: got %h expected %h", got_v, exp_v);
        end
    endtask

    task automatic test_ascii_max();
        apply(1'b0, 7'h39, 7'h39, 7'h39, 7'h39);
        exp_v = sb.pop_front();
        got_v = observed();
        n_cmp++;
        if (got_v !== exp_v || {YC, YD, YU} !== 12'h198 || YC_ASC !== 7'h31) begin
            n_err++;
            $display("FAIL ascii_99_99: got %h expected %h", got_v, exp_v);
        end
        apply(1'b0, 7'd0, 7'h30, 7'h30, 7'd0);
        exp_v = sb.pop_front();
        got_v = observed();
        n_cmp++;
        if (got_v !== exp_v || {YC, YD, YU} !== 12'h000) begin
            n_err++;
            $display("FAIL zero_sum: got %h expected %h", got_v, exp_v);
        end
    endtask

    task automatic test_carry_chain();
        apply(1'b0, 7'd9, 7'd5, 7'h30, 7'h35);
        exp_v = sb.pop_front();
        got_v = observed();
        n_cmp++;
        if (got_v !== exp_v || {YC, YD, YU} !== 12'h100) begin
            n_err++;
            $display("FAIL carry_95_05: got %h expected %h", got_v, exp_v);
        end
        apply(1'b0, 7'h30, 7'd9, 7'd0, 7'h31);
        exp_v = sb.pop_front();
        got_v = observed();
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL carry_09_01: got %h expected %h", got_v, exp_v);
        end
    endtask

    task automatic test_invalid();
        logic [6:0] bad[4];
        bad[0] = 7'h0C;
        bad[1] = 7'h3A;
        bad[2] = 7'h2F;
        bad[3] = 7'h7F;
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, (i == 2) ? bad[i] : 7'd5, (i == 0) ? bad[i] : 7'd6,
                  (i == 1) ? bad[i] : 7'h37, (i == 3) ? bad[i] : 7'd8);
            exp_v = sb.pop_front();
            got_v = observed();
            n_cmp++;
            if (got_v !== exp_v || ERR !== 1'b1) begin
                n_err++;
                $display("FAIL invalid[%0d]: got %h expected %h", i, got_v, exp_v);
            end
        end
        apply(1'b0, 7'd1, 7'd2, 7'd3, 7'd4);
        exp_v = sb.pop_front();
        got_v = observed();
        n_cmp++;
        if (got_v !== exp_v || ERR !== 1'b0) begin
            n_err++;
            $display("FAIL invalid_clear: got %h expected %h", got_v, exp_v);
        end
    endtask

    task automatic test_back_to_back_reset();
        apply(1'b0, 7'd8, 7'd8, 7'd7, 7'd7);
        apply(1'b1, 7'd8, 7'd8, 7'd7, 7'd7);
        apply(1'b0, 7'h36, 7'd6, 7'd3, 7'h34);
        for (int i = 0; i < 3; i++) begin
            exp_v = sb.pop_front();
            if (i == 2) begin
                got_v = observed();
                n_cmp++;
                if (got_v !== exp_v) begin
                    n_err++;
                    $display("FAIL reset_resume: got %h expected %h", got_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_random_sweep();
        int rst_at;
        logic [6:0] ad, au, bd, bu;
        rst_at = $urandom_range(8, 70);
        ad = 7'd0; au = 7'd0; bd = 7'd0; bu = 7'd0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (cyc % 4 == 0) begin
                ad = rand_digit();
                au = rand_digit();
                bd = rand_digit();
                bu = rand_digit();
            end
            apply(cyc == rst_at, ad, au, bd, bu);
            exp_v = sb.pop_front();
            got_v = observed();
            n_cmp++;
            if (got_v !== exp_v || YC[3:1] !== 3'b000) begin
                n_err++;
                $display("FAIL sweep[%0d] rst=%0b in=%h/%h/%h/%h: got %h expected %h",
                         cyc, (cyc == rst_at), ad, au, bd, bu, got_v, exp_v);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        AD  = 7'd0;
        AU  = 7'd0;
        BD  = 7'd0;
        BU  = 7'd0;
        @(negedge clk);
        test_reset();
        test_raw();
        test_ascii_max();
        test_carry_chain();
        test_invalid();
        test_back_to_back_reset();
        test_random_sweep();
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
